tile_reader: RTL and testbench

Scratchpad tile reader that sits directly upstream of the row/column data lanes. On a start pulse it converts an element-address range into scratchpad word addresses, issues one-cycle-latency SRAM reads and buffers the returned words in a 2-entry skid buffer. It then broadcasts each word with its word address to all lanes. A lane-side stall holds the current word, so no word is ever dropped while any lane lacks FIFO slots.

---
 rtl/tile_reader.sv | 151 +++++++++++++++
 tb/tb_tile_reader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tile_reader.sv
`timescale 1ns/1ps
// tile_reader: converts an element range into scratchpad word reads and broadcasts each word to the lanes.
// Define TILE_READER_PERF_EN to add the saturating o_stall_cycles counter.
module tile_reader #(
    parameter int SPAD_DATA_WIDTH = 64,
    parameter int DATA_WIDTH      = 8,
    parameter int ADDR_WIDTH      = 8,
    parameter int SPAD_N          = SPAD_DATA_WIDTH / DATA_WIDTH
) (
    input  logic                       i_clk,
    input  logic                       i_nrst,
    input  logic                       i_reg_clear,
    input  logic                       i_start,
    input  logic [ADDR_WIDTH-1:0]      i_start_addr,
    input  logic [ADDR_WIDTH-1:0]      i_end_addr,
    input  logic                       i_stall,
    output logic                       o_spad_rd_en,
    output logic [ADDR_WIDTH-1:0]      o_spad_addr,
    input  logic [SPAD_DATA_WIDTH-1:0] i_spad_data,
    output logic [SPAD_DATA_WIDTH-1:0] o_data,
    output logic                       o_data_valid,
    output logic [ADDR_WIDTH-1:0]      o_addr,
    output logic                       o_busy,
    output logic                       o_done
`ifdef TILE_READER_PERF_EN
    ,
    output logic [15:0]                o_stall_cycles
`endif
);
    localparam int SHIFT = $clog2(SPAD_N);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t                     r_state, w_next;
    logic [ADDR_WIDTH-1:0]      r_rd_addr, r_last;
    logic                       r_inflight;
    logic [ADDR_WIDTH-1:0]      r_inflight_addr;
    logic                       r_valid, r_sk_valid;
    logic [SPAD_DATA_WIDTH-1:0] r_data, r_sk_data;
    logic [ADDR_WIDTH-1:0]      r_addr, r_sk_addr;
    logic                       w_consume, w_head_free, w_rd_en, w_start_acc;
    logic [1:0]                 w_pending;

    assign w_consume   = r_valid & ~i_stall;
    assign w_head_free = ~r_valid | ~i_stall;
    assign w_start_acc = (r_state == S_IDLE) & i_start;
    // Words held or owed to the buffer after this cycle's transfer.
    assign w_pending   = 2'(r_valid) + 2'(r_sk_valid) + 2'(r_inflight) - 2'(w_consume);

    always_comb begin
        w_next  = r_state;
        w_rd_en = 1'b0;
        case (r_state)
            // An empty range passes through DRAIN, which exits at once, so o_done lands two cycles after start.
            S_IDLE:  if (i_start) w_next = (i_start_addr >= i_end_addr) ? S_DRAIN : S_READ;
            S_READ: begin
                if (w_pending < 2'd2) begin
                    w_rd_en = 1'b1;
                    if (r_rd_addr == r_last) w_next = S_DRAIN;
                end
            end
            S_DRAIN: if (w_pending == 2'd0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state         <= S_IDLE;
            r_rd_addr       <= '0;
            r_last          <= '0;
            r_inflight      <= 1'b0;
            r_inflight_addr <= '0;
        end else if (i_reg_clear) begin
            r_state    <= S_IDLE;
            r_inflight <= 1'b0;
        end else begin
            r_state         <= w_next;
            r_inflight      <= w_rd_en;
            r_inflight_addr <= r_rd_addr;
            if (w_start_acc) begin
                r_rd_addr <= i_start_addr >> SHIFT;
                r_last    <= (i_end_addr - ADDR_WIDTH'(1)) >> SHIFT;
            end else if (w_rd_en && (r_rd_addr != r_last)) begin
                r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
            end
        end
    end

    // Head entry drives the lanes directly; the skid entry catches a return that arrives while the head is stalled.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_addr     <= '0;
            r_sk_valid <= 1'b0;
            r_sk_data  <= '0;
            r_sk_addr  <= '0;
        end else if (i_reg_clear) begin
            r_valid    <= 1'b0;
            r_sk_valid <= 1'b0;
        end else if (w_head_free) begin
            if (r_sk_valid) begin
                r_valid    <= 1'b1;
                r_data     <= r_sk_data;
                r_addr     <= r_sk_addr;
                r_sk_valid <= r_inflight;
                if (r_inflight) begin
                    r_sk_data <= i_spad_data;
                    r_sk_addr <= r_inflight_addr;
                end
            end else begin
                r_valid <= r_inflight;
                if (r_inflight) begin
                    r_data <= i_spad_data;
                    r_addr <= r_inflight_addr;
                end
            end
        end else if (r_inflight) begin
            r_sk_valid <= 1'b1;
            r_sk_data  <= i_spad_data;
            r_sk_addr  <= r_inflight_addr;
        end
    end

`ifdef TILE_READER_PERF_EN
    logic [15:0] r_stall_cnt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst)                        r_stall_cnt <= '0;
        else if (i_reg_clear || w_start_acc) r_stall_cnt <= '0;
        else if (r_valid && i_stall)        r_stall_cnt <= sat_inc(r_stall_cnt);
    end

    assign o_stall_cycles = r_stall_cnt;
`endif

    assign o_spad_rd_en = w_rd_en;
    assign o_spad_addr  = r_rd_addr;
    assign o_data       = r_data;
    assign o_addr       = r_addr;
    assign o_data_valid = r_valid;
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = (r_state == S_DONE);

endmodule

// File: tb/tb_tile_reader.sv
`timescale 1ns/1ps
// tb_tile_reader: vector table, clear/perf sequences and randomized transfers against a word-list model.
module tb_tile_reader;
    localparam int SW = 64, DW = 8, AW = 8, N = SW / DW;

    logic          clk = 1'b0;
    logic          nrst, clr, start_i, stall;
    logic [AW-1:0] sa, ea;
    logic          rd_en;
    logic [AW-1:0] spad_addr, o_addr;
    logic [SW-1:0] spad_data, o_data;
    logic          o_valid, o_busy, o_done;
`ifdef TILE_READER_PERF_EN
    logic [15:0]   o_stall_cycles;
`endif

    always #5 clk = ~clk;

    tile_reader #(.SPAD_DATA_WIDTH(SW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk(clk), .i_nrst(nrst), .i_reg_clear(clr), .i_start(start_i),
        .i_start_addr(sa), .i_end_addr(ea), .i_stall(stall),
        .o_spad_rd_en(rd_en), .o_spad_addr(spad_addr), .i_spad_data(spad_data),
        .o_data(o_data), .o_data_valid(o_valid), .o_addr(o_addr),
        .o_busy(o_busy), .o_done(o_done)
`ifdef TILE_READER_PERF_EN
        , .o_stall_cycles(o_stall_cycles)
`endif
    );

    logic [SW-1:0] mem [256];
    always @(posedge clk) if (rd_en) spad_data <= mem[spad_addr];

    int n_chk = 0, n_fail = 0;
    int cyc = 0, first_v, done_cyc, n_xfer, n_rd, n_done, busy_cnt, ist;
    int xq[$], rq[$];
    logic hold_v = 1'b0;
    logic [SW-1:0] hold_d;
    logic [AW-1:0] hold_a;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: read order, transfer order/data, hold under stall, outstanding words, done completeness.
    always @(negedge clk) begin
        if (!nrst || clr) begin
            xq.delete(); rq.delete(); hold_v = 1'b0; ist = 0;
        end else begin
            if (rd_en) begin
                n_rd++; ist++;
                if (rq.size() == 0) chk("rd_unexpected", 1, 0);
                else chk("rd_addr", spad_addr, rq.pop_front());
            end
            if (hold_v) begin
                chk("hold_valid", o_valid, 1);
                chk("hold_data", o_data, hold_d);
                chk("hold_addr", o_addr, hold_a);
            end
            if (o_valid && first_v < 0) first_v = cyc;
            if (o_valid && !stall) begin
                n_xfer++; ist--;
                if (xq.size() == 0) chk("xfer_unexpected", 1, 0);
                else begin
                    automatic int w = xq.pop_front();
                    chk("xfer_addr", o_addr, w);
                    chk("xfer_data", o_data, mem[w]);
                end
            end
            if (rd_en) chk("outstanding_le2", (ist <= 2), 1);
            hold_v = o_valid && stall; hold_d = o_data; hold_a = o_addr;
            if (o_busy) busy_cnt++;
            if (o_done) begin
                n_done++; done_cyc = cyc;
                chk("done_all_xferred", xq.size(), 0);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk); #1; cyc++;
    endtask

    // Reference model: the ordered list of word addresses covering [s, e).
    function automatic int nwords(input int s, input int e);
        return (s < e) ? ((e - 1) / N - s / N + 1) : 0;
    endfunction

    task automatic do_start(input int s, input int e);
        @(posedge clk); #1;
        start_i = 1'b1; sa = AW'(s); ea = AW'(e); cyc = 0;
        first_v = -1; done_cyc = -1; n_xfer = 0; n_rd = 0; n_done = 0; busy_cnt = 0;
        for (int w = s / N; w < s / N + nwords(s, e); w++) begin
            xq.push_back(w); rq.push_back(w);
        end
        next_cycle();
        start_i = 1'b0;
    endtask

    task automatic run(input logic [31:0] mask, input int pct, input int limit);
        forever begin
            if (pct > 0) begin
                stall = ($urandom_range(0, 99) < pct);
                if (done_cyc < 0 && $urandom_range(0, 9) == 0) begin
                    start_i = 1'b1; sa = AW'($urandom_range(0, 255)); ea = AW'($urandom_range(0, 255));
                end else start_i = 1'b0;
            end else stall = (cyc < 32) ? mask[cyc] : 1'b0;
            @(negedge clk); #1;
            if (done_cyc >= 0 && cyc > done_cyc) break;
            if (cyc >= limit) begin
                n_chk++; n_fail++;
                $display("FAIL timeout: no o_done after %0d cycles", cyc);
                break;
            end
            next_cycle();
        end
        stall = 1'b0; start_i = 1'b0;
    endtask

    typedef struct {
        int s; int e; logic [31:0] mask;
        int words; int first_v; int done_c;
    } vec_t;

    initial begin
        automatic vec_t vecs[9];
        vecs[0] = '{3, 20, 32'h0, 3, 3, 6};
        vecs[1] = '{3, 20, 32'h78, 3, 3, 10};
        vecs[2] = '{16, 16, 32'h0, 0, -1, 2};
        vecs[3] = '{0, 8, 32'h0, 1, 3, 4};
        vecs[4] = '{7, 9, 32'h0, 2, 3, 5};
        vecs[5] = '{250, 255, 32'h0, 1, 3, 4};
        vecs[6] = '{5, 0, 32'h0, 0, -1, 2};
        vecs[7] = '{0, 255, 32'h0, 32, 3, 35};
        vecs[8] = '{0, 24, 32'h10, 3, 3, 7};

        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
        nrst = 1'b0; clr = 1'b0; start_i = 1'b0; stall = 1'b0; sa = '0; ea = '0;
        repeat (3) @(negedge clk);
        chk("rst_data", o_data, 0);
        chk("rst_addr", o_addr, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_spad_addr", spad_addr, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
`ifdef TILE_READER_PERF_EN
        chk("rst_stall_cycles", o_stall_cycles, 0);
`endif
        @(posedge clk); #1; nrst = 1'b1;

        foreach (vecs[i]) begin
            do_start(vecs[i].s, vecs[i].e);
            run(vecs[i].mask, 0, 100);
            chk($sformatf("v%0d_words", i), n_xfer, vecs[i].words);
            chk($sformatf("v%0d_reads", i), n_rd, vecs[i].words);
            chk($sformatf("v%0d_first_valid", i), first_v, vecs[i].first_v);
            chk($sformatf("v%0d_done_cycle", i), done_cyc, vecs[i].done_c);
            chk($sformatf("v%0d_done_once", i), n_done, 1);
            chk($sformatf("v%0d_busy_cycles", i), busy_cnt, vecs[i].done_c);
        end

        // Clear with word 0 buffered and word 1 in flight.
        do_start(0, 64);
        next_cycle(); next_cycle();
        stall = 1'b1; clr = 1'b1;
        @(negedge clk);
        chk("clr_pre_valid", o_valid, 1);
        chk("clr_pre_busy", o_busy, 1);
        next_cycle();
        clr = 1'b0; stall = 1'b0;
        @(negedge clk);
        chk("clr_valid", o_valid, 0);
        chk("clr_busy", o_busy, 0);
        chk("clr_rd_en", rd_en, 0);
        chk("clr_done", o_done, 0);
        repeat (5) next_cycle();
        chk("clr_no_done", n_done, 0);
        chk("clr_no_xfer", n_xfer, 0);
        do_start(3, 20);
        run(32'h0, 0, 100);
        chk("after_clr_words", n_xfer, 3);
        chk("after_clr_done_cycle", done_cyc, 6);

        for (int t = 0; t < 40; t++) begin
            automatic int s = $urandom_range(0, 255);
            automatic int e = s + $urandom_range(0, 48) - 4;
            if (e < 0) e = 0;
            if (e > 255) e = 255;
            do_start(s, e);
            run(32'h0, 30, 400);
            chk("rnd_words", n_xfer, nwords(s, e));
            chk("rnd_reads", n_rd, nwords(s, e));
            chk("rnd_done_once", n_done, 1);
        end

`ifdef TILE_READER_PERF_EN
        do_start(0, 8);
        run(32'h78, 0, 50);
        chk("perf_four", o_stall_cycles, 4);
        do_start(0, 8);
        @(negedge clk);
        chk("perf_clear_on_start", o_stall_cycles, 0);
        stall = 1'b1;
        repeat (70000) next_cycle();
        @(negedge clk);
        chk("perf_saturate", o_stall_cycles, 65535);
        run(32'h0, 0, cyc + 50);
        chk("perf_sat_words", n_xfer, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
